// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module : pc_sequencer_pkg
// Brief  : Shared defaults and next-PC select encoding for the PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam int unsigned     c_XLEN      = 32;
    localparam logic [31:0]     c_RESET_VEC = 32'h0000_0000;
    localparam int unsigned     c_RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_CALL = 2'd2,
        SEL_RET  = 2'd3
    } next_pc_sel_e;

endpackage : pc_sequencer_pkg

`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
// ============================================================================
// Module : pc_sequencer_ras_stack
// Brief  : Circular return-address LIFO; overwrites the oldest entry when full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer_ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full
);

    localparam int unsigned c_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;     // next free slot; top lives at r_ptr-1
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop_ok;
    logic               w_replace;
    logic [c_PTR_W-1:0] w_top_idx;
    logic [c_PTR_W-1:0] w_wr_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_replace = i_push & w_pop_ok;
    assign w_top_idx = r_ptr - 1'b1;
    assign w_wr_idx  = w_replace ? w_top_idx : r_ptr;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_replace) begin
            r_ptr   <= r_ptr;
            r_count <= r_count;
        end else if (i_push) begin
            // When full, r_ptr already points at the oldest entry.
            r_ptr   <= r_ptr + 1'b1;
            r_count <= w_full ? r_count : r_count + 1'b1;
        end else if (w_pop_ok) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule : pc_sequencer_ras_stack

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Program counter register with branch/call/return next-PC select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN      = c_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(c_RESET_VEC),
    parameter int unsigned     RAS_DEPTH = c_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow,
    output logic            pc_misaligned
);

    logic [XLEN-1:0] r_pc;
    logic            r_underflow;
    logic            r_misaligned;

    next_pc_sel_e    w_sel;
    logic [XLEN-1:0] w_next_pc;
    logic            w_underflow;
    logic            w_misaligned;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    assign w_push = ~stall & is_call;
    assign w_pop  = ~stall & is_ret;

    pc_sequencer_ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (pc_plus4),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    always_comb begin
        if (is_ret)            w_sel = SEL_RET;
        else if (is_call)      w_sel = SEL_CALL;
        else if (branch_taken) w_sel = SEL_BR;
        else                   w_sel = SEL_SEQ;
    end

    // Explicit targets are word-aligned on load; RAS and sequential values are trusted.
    always_comb begin
        w_next_pc    = pc_plus4;
        w_underflow  = 1'b0;
        w_misaligned = 1'b0;
        case (w_sel)
            SEL_RET: begin
                if (w_ras_empty) begin
                    w_next_pc   = pc_plus4;
                    w_underflow = 1'b1;
                end else begin
                    w_next_pc   = w_ras_top;
                end
            end
            SEL_CALL: begin
                w_next_pc    = {jump_target[XLEN-1:2], 2'b00};
                w_misaligned = |jump_target[1:0];
            end
            SEL_BR: begin
                w_next_pc    = {branch_target[XLEN-1:2], 2'b00};
                w_misaligned = |branch_target[1:0];
            end
            default: w_next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_VEC;
            r_underflow  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (stall) begin
            r_pc         <= r_pc;
            r_underflow  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            r_underflow  <= w_underflow;
            r_misaligned <= w_misaligned;
        end
    end

    assign pc            = r_pc;
    assign ras_top       = w_ras_top;
    assign ras_empty     = w_ras_empty;
    assign ras_full      = w_ras_full;
    assign ras_underflow = r_underflow;
    assign pc_misaligned = r_misaligned;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module : tb_pc_sequencer
// Brief  : Scoreboard bench for pc_sequencer with an independent queue-based RAS model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int unsigned c_XLEN  = 32;
    localparam int unsigned c_DEPTH = 8;
    localparam logic [31:0] c_RVEC  = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        is_call;
    logic        is_ret;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
    logic        pc_misaligned;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic        uf;
        logic        mis;
    } exp_t;

    exp_t        r_sb [$];
    logic [31:0] r_model_ras [$];
    logic [31:0] r_model_pc;
    int          n_checks;
    int          n_errors;

    pc_sequencer #(
        .XLEN      (c_XLEN),
        .RESET_VEC (c_RVEC),
        .RAS_DEPTH (c_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .is_call       (is_call),
        .is_ret        (is_ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .ras_top       (ras_top),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow),
        .pc_misaligned (pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_snapshot(input logic uf, input logic mis);
        exp_t e;
        e.pc    = r_model_pc;
        e.top   = (r_model_ras.size() == 0) ? 32'h0 : r_model_ras[$];
        e.empty = (r_model_ras.size() == 0);
        e.full  = (r_model_ras.size() == c_DEPTH);
        e.uf    = uf;
        e.mis   = mis;
        return e;
    endfunction

    task automatic model_push(input logic [31:0] v);
        if (r_model_ras.size() == c_DEPTH) void'(r_model_ras.pop_front());
        r_model_ras.push_back(v);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (r_sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = r_sb.pop_front();
        check({tag, "_pc"},    pc,                   e.pc);
        check({tag, "_top"},   ras_top,              e.top);
        check({tag, "_empty"}, {31'd0, ras_empty},     {31'd0, e.empty});
        check({tag, "_full"},  {31'd0, ras_full},      {31'd0, e.full});
        check({tag, "_uf"},    {31'd0, ras_underflow}, {31'd0, e.uf});
        check({tag, "_mis"},   {31'd0, pc_misaligned}, {31'd0, e.mis});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; is_call = 1'b0; is_ret = 1'b0;
        pc_plus4 = 32'h0; branch_target = 32'h0; jump_target = 32'h0;
        r_model_pc = c_RVEC;
        r_model_ras.delete();
        r_sb.push_back(model_snapshot(1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 compare_out(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle of stimulus: model predicts, DUT result compared after the edge.
    task automatic cyc(input string tag, input logic st, input logic [31:0] pp4,
                       input logic br, input logic [31:0] bt,
                       input logic call, input logic ret, input logic [31:0] jt);
        logic uf;
        logic mis;
        uf  = 1'b0;
        mis = 1'b0;
        @(negedge clk);
        stall = st; pc_plus4 = pp4; branch_taken = br; branch_target = bt;
        is_call = call; is_ret = ret; jump_target = jt;
        if (!st) begin
            if (ret) begin
                if (r_model_ras.size() == 0) begin
                    r_model_pc = pp4;
                    uf = 1'b1;
                    if (call) model_push(pp4);
                end else begin
                    r_model_pc = r_model_ras[$];
                    if (call) r_model_ras[r_model_ras.size()-1] = pp4;
                    else void'(r_model_ras.pop_back());
                end
            end else if (call) begin
                r_model_pc = jt & 32'hFFFF_FFFC;
                mis = (jt[1:0] != 2'b00);
                model_push(pp4);
            end else if (br) begin
                r_model_pc = bt & 32'hFFFF_FFFC;
                mis = (bt[1:0] != 2'b00);
            end else begin
                r_model_pc = pp4;
            end
        end
        r_sb.push_back(model_snapshot(uf, mis));
        @(posedge clk);
        #1 compare_out(tag);
    endtask

    task automatic seq(input string tag);
        cyc(tag, 1'b0, r_model_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; stall = 1'b0; pc_plus4 = 32'h0; branch_taken = 1'b0;
        branch_target = 32'h0; is_call = 1'b0; is_ret = 1'b0; jump_target = 32'h0;

        do_reset("reset");

        seq("seq0"); seq("seq1"); seq("seq2");
        cyc("stall_hold", 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0);

        cyc("br_200", 1'b0, r_model_pc + 32'd4, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
        cyc("call_400", 1'b0, 32'h0000_0204, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0400);
        cyc("stall_ret", 1'b1, 32'h0000_0404, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        cyc("ret_204", 1'b0, 32'h0000_0404, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 9; i++)
            cyc("ovf_call", 1'b0, 32'h10 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0,
                32'h0000_1000 + 32'(16 * i));
        for (int i = 0; i < 8; i++)
            cyc("ovf_ret", 1'b0, r_model_pc + 32'd4, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        cyc("underflow", 1'b0, 32'h0000_0700, 1'b1, 32'h0000_0900, 1'b0, 1'b1, 32'h0);
        seq("uf_clear");

        cyc("call_204", 1'b0, 32'h0000_0204, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0500);
        cyc("ret_call", 1'b0, 32'h0000_0504, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0600);
        cyc("call_br", 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0A00, 1'b1, 1'b0, 32'h0000_0B00);
        cyc("ret_b", 1'b0, 32'h0000_0B04, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        cyc("ret_c", 1'b0, 32'h0000_020C, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        cyc("ret_call_empty", 1'b0, 32'h0000_0510, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0C00);

        cyc("mis_br", 1'b0, r_model_pc + 32'd4, 1'b1, 32'h0000_0302, 1'b0, 1'b0, 32'h0);
        seq("mis_clear");
        cyc("mis_call", 1'b0, r_model_pc + 32'd4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0403);
        cyc("mis_stall", 1'b1, r_model_pc + 32'd4, 1'b1, 32'h0000_0301, 1'b0, 1'b0, 32'h0);

        cyc("wrap_br", 1'b0, r_model_pc + 32'd4, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        seq("wrap_seq");

        cyc("pre_rst_call", 1'b0, 32'h0000_0044, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080);
        do_reset("reset_mid");
        cyc("ret_after_rst", 1'b0, 32'h0000_0104, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_sequencer

`default_nettype wire
